// File: rtl/reset_sequencer.sv
// Ordered, stretched reset generator for NUM_DOMAINS block resets with soft-reset drain,
// drain timeout, done/busy flags and a record of the last reset cause.
module reset_sequencer #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STRETCH_CYCLES = 128,
  parameter int unsigned STAGE_GAP      = 8,
  parameter int unsigned DRAIN_TIMEOUT  = 1024
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   soft_rst_req,
  input  logic                   quiesce_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   rst_done,
  output logic                   busy,
  output logic [1:0]             last_cause
);

  localparam int unsigned MaxSg   = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int unsigned MaxTerm = (MaxSg > DRAIN_TIMEOUT) ? MaxSg : DRAIN_TIMEOUT;
  localparam int unsigned CntW    = $clog2(MaxTerm + 1) + 1;
  localparam int unsigned SyncW   = SYNC_STAGES - 1;

  localparam logic [CntW-1:0] StretchLast = CntW'(STRETCH_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);
  localparam logic [CntW-1:0] DrainLast   = CntW'(DRAIN_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax      = '1;

  localparam logic [SyncW-1:0]       SyncOne      = SyncW'(1);
  localparam logic [NUM_DOMAINS-1:0] AllReleased  = '1;
  localparam logic [NUM_DOMAINS-1:0] ReleaseFirst = NUM_DOMAINS'(1);

  typedef enum logic [2:0] {
    StPor,
    StHold,
    StRelease,
    StRun,
    StDrain
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [CntW-1:0]        cnt_inc;
  logic [SyncW-1:0]       sync_q;
  logic [NUM_DOMAINS-1:0] rst_n_q;
  logic                   done_q;
  logic                   busy_q;
  logic [1:0]             cause_q;

  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  end

  // The POR->HOLD transition acts as the final synchroniser stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StPor;
      cnt_q   <= '0;
      sync_q  <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      cause_q <= 2'b00;
    end else begin
      sync_q <= (sync_q << 1) | SyncOne;
      case (state_q)
        StPor: begin
          if (sync_q[SyncW-1]) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end
        end
        StHold: begin
          if (cnt_q == StretchLast) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            rst_n_q <= (STAGE_GAP == 0) ? AllReleased : ReleaseFirst;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRelease: begin
          if (rst_n_q == AllReleased) begin
            state_q <= StRun;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else if (cnt_q == GapLast) begin
            // Released bits form a contiguous run from bit 0; extend it by one.
            rst_n_q <= rst_n_q | (rst_n_q << 1);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRun: begin
          if (soft_rst_req) begin
            state_q <= StDrain;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StDrain: begin
          if (quiesce_i || (cnt_q == DrainLast)) begin
            state_q <= StHold;
            cnt_q   <= '0;
            rst_n_q <= '0;
            cause_q <= quiesce_i ? 2'b01 : 2'b10;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StPor;
      endcase
    end
  end

  assign rst_n_o    = rst_n_q;
  assign rst_done   = done_q;
  assign busy       = busy_q;
  assign last_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: one staged build (N=3, GAP=4) and two GAP=0 builds.
module tb_reset_sequencer;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       soft_a;
  logic       q_a;
  logic [2:0] rst_a;
  logic       done_a, busy_a;
  logic [1:0] cause_a;
  logic [0:0] rst_b;
  logic       done_b, busy_b;
  logic [1:0] cause_b;
  logic [3:0] rst_c;
  logic       done_c, busy_c;
  logic [1:0] cause_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 aclk = ~aclk;

  reset_sequencer #(
    .NUM_DOMAINS(3), .SYNC_STAGES(2), .STRETCH_CYCLES(16), .STAGE_GAP(4), .DRAIN_TIMEOUT(32)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn), .soft_rst_req(soft_a), .quiesce_i(q_a),
    .rst_n_o(rst_a), .rst_done(done_a), .busy(busy_a), .last_cause(cause_a)
  );

  reset_sequencer #(
    .NUM_DOMAINS(1), .SYNC_STAGES(2), .STRETCH_CYCLES(16), .STAGE_GAP(0), .DRAIN_TIMEOUT(32)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn), .soft_rst_req(1'b0), .quiesce_i(1'b0),
    .rst_n_o(rst_b), .rst_done(done_b), .busy(busy_b), .last_cause(cause_b)
  );

  reset_sequencer #(
    .NUM_DOMAINS(4), .SYNC_STAGES(2), .STRETCH_CYCLES(16), .STAGE_GAP(0), .DRAIN_TIMEOUT(32)
  ) dut_c (
    .aclk(aclk), .aresetn(aresetn), .soft_rst_req(1'b0), .quiesce_i(1'b0),
    .rst_n_o(rst_c), .rst_done(done_c), .busy(busy_c), .last_cause(cause_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Expected staged outputs, s = edges since the edge that entered HOLD.
  function automatic logic [2:0] exp_a(input int s);
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (s >= 16 + 4 * i);
    return r;
  endfunction

  task automatic release_loop(input int from, input int to, input bit with_bc,
                              input logic [1:0] cause);
    for (int s = from; s <= to; s++) begin
      tick();
      check($sformatf("a_rst s=%0d", s), 32'(rst_a), 32'(exp_a(s)));
      check($sformatf("a_done s=%0d", s), 32'(done_a), 32'(s >= 25));
      check($sformatf("a_busy s=%0d", s), 32'(busy_a), 32'(s < 25));
      if (with_bc) begin
        check($sformatf("b_rst s=%0d", s), 32'(rst_b), 32'(s >= 16));
        check($sformatf("b_done s=%0d", s), 32'(done_b), 32'(s >= 17));
        check($sformatf("c_rst s=%0d", s), 32'(rst_c), (s >= 16) ? 32'hF : 32'h0);
        check($sformatf("c_done s=%0d", s), 32'(done_c), 32'(s >= 17));
        check($sformatf("c_busy s=%0d", s), 32'(busy_c), 32'(s < 17));
      end
    end
    check("a_cause", 32'(cause_a), 32'(cause));
  endtask

  initial begin
    aresetn = 1'b0;
    soft_a  = 1'b0;
    q_a     = 1'b0;
    #12;
    check("rst_rst_a", 32'(rst_a), 32'h0);
    check("rst_done_a", 32'(done_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h1);
    check("rst_cause_a", 32'(cause_a), 32'h0);
    check("rst_rst_c", 32'(rst_c), 32'h0);

    // Power-on: edge 1 at t=15; since-HOLD index is edge-2.
    aresetn = 1'b1;
    release_loop(-1, 28, 1'b1, 2'b00);

    // Soft reset, quiesce seen on the 5th DRAIN edge.
    soft_a = 1'b1;
    tick();
    soft_a = 1'b0;
    check("drain_done", 32'(done_a), 32'h0);
    check("drain_busy", 32'(busy_a), 32'h1);
    check("drain_rst", 32'(rst_a), 32'h7);
    for (int j = 1; j <= 4; j++) begin
      tick();
      check($sformatf("drain_hold j=%0d", j), 32'(rst_a), 32'h7);
    end
    q_a = 1'b1;
    tick();
    q_a = 1'b0;
    check("clean_rst", 32'(rst_a), 32'h0);
    check("clean_cause", 32'(cause_a), 32'h1);
    release_loop(1, 26, 1'b0, 2'b01);

    // Soft reset with quiesce held low: timeout after 32 edges.
    soft_a = 1'b1;
    tick();
    soft_a = 1'b0;
    check("to_busy", 32'(busy_a), 32'h1);
    for (int j = 1; j <= 31; j++) begin
      tick();
      check($sformatf("to_wait j=%0d", j), 32'(rst_a), 32'h7);
    end
    tick();
    check("to_rst", 32'(rst_a), 32'h0);
    check("to_cause", 32'(cause_a), 32'h2);

    // Request held through HOLD/RELEASE: no effect until RUN.
    soft_a = 1'b1;
    release_loop(1, 25, 1'b0, 2'b10);
    tick();
    soft_a = 1'b0;
    check("held_drain_done", 32'(done_a), 32'h0);
    check("held_drain_busy", 32'(busy_a), 32'h1);
    check("held_drain_rst", 32'(rst_a), 32'h7);

    // Quiesce arriving on the timeout edge counts as clean.
    for (int j = 1; j <= 31; j++) begin
      tick();
      check($sformatf("edge_wait j=%0d", j), 32'(rst_a), 32'h7);
    end
    q_a = 1'b1;
    tick();
    q_a = 1'b0;
    check("edge_rst", 32'(rst_a), 32'h0);
    check("edge_cause", 32'(cause_a), 32'h1);
    release_loop(1, 18, 1'b0, 2'b01);
    check("mid_release", 32'(rst_a), 32'h1);

    // 1 ns aresetn pulse mid-RELEASE.
    aresetn = 1'b0;
    #1;
    check("async_rst_a", 32'(rst_a), 32'h0);
    check("async_done_a", 32'(done_a), 32'h0);
    check("async_busy_a", 32'(busy_a), 32'h1);
    check("async_cause_a", 32'(cause_a), 32'h0);
    check("async_rst_b", 32'(rst_b), 32'h0);
    check("async_rst_c", 32'(rst_c), 32'h0);
    check("async_busy_c", 32'(busy_c), 32'h1);
    aresetn = 1'b1;
    release_loop(-1, 28, 1'b1, 2'b00);
    check("final_cause_b", 32'(cause_b), 32'h0);
    check("final_cause_c", 32'(cause_c), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
